// File: rtl/rx_inband_pkg.sv
// rtl/rx_inband_pkg.sv - shared encodings and constants for the inband RX path
package rx_inband_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_START = 2'd2,
    ST_WAIT  = 2'd3
  } rx_state_t;

  localparam logic [6:0] RX_CFG_ADDR      = 7'd80;
  localparam int         RX_PKT_WORDS     = 256;
  localparam int         RX_PAYLOAD_WORDS = 252;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker starting after the last winner
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = 4
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] last,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [IW:0]  cand;
  logic [N-1:0] elig_sh;

  // Walk last+1 .. last+N modulo N; the first eligible source wins.
  always_comb begin
    found   = 1'b0;
    idx     = '0;
    cand    = '0;
    elig_sh = '0;
    for (int k = 1; k <= N; k++) begin
      cand = {1'b0, last} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) begin
        cand = cand - (IW+1)'(N);
      end
      // Shift instead of indexing so the candidate width never has to match N.
      elig_sh = elig >> cand;
      if (!found && elig_sh[0]) begin
        found = 1'b1;
        idx   = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/rx_pkt_scheduler.sv
// rtl/rx_pkt_scheduler.sv - per-packet source arbiter between RX FIFOs and the packet builder
module rx_pkt_scheduler
  import rx_inband_pkg::*;
#(
  parameter int         NUM_CHAN      = 2,
  parameter int         PAYLOAD_WORDS = RX_PAYLOAD_WORDS,
  parameter logic [6:0] CFG_ADDR      = RX_CFG_ADDR,
  parameter int         TIMEOUT       = 1024
) (
  input  logic                      rxclk,
  input  logic                      reset,
  input  logic [10*(NUM_CHAN+1)-1:0] chan_usedw_flat,
  input  logic                      cmd_empty,
  input  logic                      have_space,
  input  logic                      pkt_done,
  input  logic                      clear_status,
  input  logic [6:0]                serial_addr,
  input  logic [31:0]               serial_data,
  input  logic                      serial_strobe,
  output logic [3:0]                rd_select,
  output logic                      pkt_start,
  output logic                      busy,
  output logic                      timeout_err,
  output logic [15:0]               grant_count
);

  localparam int               NSRC    = NUM_CHAN + 1;
  localparam int               WDW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [9:0]       PAY_LVL = 10'(PAYLOAD_WORDS);
  localparam logic [WDW-1:0]   WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [3:0]       CMD_IDX = 4'(NUM_CHAN);

  rx_state_t       state;
  rx_state_t       state_nxt;
  logic [NSRC-1:0] enable;
  logic            cmd_prio;
  logic [NSRC-1:0] elig;
  logic            any_elig;
  logic [3:0]      last_grant;
  logic [3:0]      rr_idx;
  logic            cmd_wins;
  logic [3:0]      winner;
  logic [WDW-1:0]  wd_cnt;
  logic            wd_expired;

  // The command source's fill level and the spare config bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{serial_data, chan_usedw_flat[10*NSRC-1 -: 10]};

  // Configuration register; a write lands immediately but is only consulted at ARB.
  always_ff @(posedge rxclk) begin
    if (!reset) begin
      enable   <= '1;
      cmd_prio <= 1'b1;
    end else if (serial_strobe && (serial_addr == CFG_ADDR)) begin
      enable   <= serial_data[NSRC-1:0];
      cmd_prio <= serial_data[8];
    end
  end

  for (genvar i = 0; i < NUM_CHAN; i++) begin : g_elig
    assign elig[i] = enable[i] & (chan_usedw_flat[10*i +: 10] >= PAY_LVL) & have_space;
  end
  assign elig[NUM_CHAN] = enable[NUM_CHAN] & ~cmd_empty & have_space;

  rr_pick #(
    .N  (NSRC),
    .IW (4)
  ) u_rr_pick (
    .elig  (elig),
    .last  (last_grant),
    .found (any_elig),
    .idx   (rr_idx)
  );

  // A prioritised command grant bypasses the rotation and leaves last_grant alone.
  assign cmd_wins   = cmd_prio & elig[NUM_CHAN];
  assign winner     = cmd_wins ? CMD_IDX : rr_idx;
  assign wd_expired = (wd_cnt == WD_LAST);

  // State register.
  always_ff @(posedge rxclk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-state outputs.
  always_comb begin
    state_nxt = state;
    pkt_start = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any_elig) begin
          state_nxt = ST_ARB;
        end
      end
      ST_ARB: begin
        state_nxt = any_elig ? ST_START : ST_IDLE;
      end
      ST_START: begin
        pkt_start = 1'b1;
        busy      = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (pkt_done || wd_expired) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Latch the winner at ARB; it then holds for the whole packet.
  always_ff @(posedge rxclk) begin
    if (!reset) begin
      rd_select  <= '0;
      last_grant <= CMD_IDX;
    end else if ((state == ST_ARB) && any_elig) begin
      rd_select <= winner;
      if (!cmd_wins) begin
        last_grant <= rr_idx;
      end
    end
  end

  // Count granted packets; wraps naturally.
  always_ff @(posedge rxclk) begin
    if (!reset) begin
      grant_count <= '0;
    end else if (state == ST_START) begin
      grant_count <= grant_count + 16'd1;
    end
  end

  // Watchdog: cleared at START, counts WAIT cycles and saturates instead of wrapping.
  always_ff @(posedge rxclk) begin
    if (!reset) begin
      wd_cnt <= '0;
    end else if (state == ST_START) begin
      wd_cnt <= '0;
    end else if ((state == ST_WAIT) && (wd_cnt != '1)) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // Sticky timeout flag; a new timeout beats a simultaneous clear.
  always_ff @(posedge rxclk) begin
    if (!reset) begin
      timeout_err <= 1'b0;
    end else if ((state == ST_WAIT) && !pkt_done && wd_expired) begin
      timeout_err <= 1'b1;
    end else if (clear_status) begin
      timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rx_pkt_scheduler.sv
// tb/tb_rx_pkt_scheduler.sv - scoreboard bench for rx_pkt_scheduler
module tb_rx_pkt_scheduler;

  logic        rxclk = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  usedw [3];
  logic [29:0] chan_usedw_flat;
  logic        cmd_empty = 1'b1;
  logic        have_space = 1'b0;
  logic        pkt_done = 1'b0;
  logic        clear_status = 1'b0;
  logic [6:0]  serial_addr = 7'd0;
  logic [31:0] serial_data = 32'd0;
  logic        serial_strobe = 1'b0;
  logic [3:0]  rd_select;
  logic        pkt_start;
  logic        busy;
  logic        timeout_err;
  logic [15:0] grant_count;

  int n_cmp = 0;
  int n_err = 0;
  int starts_seen = 0;
  int exp_q [$];
  logic auto_done = 1'b1;
  int dcnt = 0;

  assign chan_usedw_flat = {usedw[2], usedw[1], usedw[0]};

  always #5 rxclk = ~rxclk;

  rx_pkt_scheduler dut (
    .rxclk           (rxclk),
    .reset           (reset),
    .chan_usedw_flat (chan_usedw_flat),
    .cmd_empty       (cmd_empty),
    .have_space      (have_space),
    .pkt_done        (pkt_done),
    .clear_status    (clear_status),
    .serial_addr     (serial_addr),
    .serial_data     (serial_data),
    .serial_strobe   (serial_strobe),
    .rd_select       (rd_select),
    .pkt_start       (pkt_start),
    .busy            (busy),
    .timeout_err     (timeout_err),
    .grant_count     (grant_count)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge rxclk);
    #1;
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    tick();
    while (!pkt_start && n < 2000) begin
      tick();
      n++;
    end
    check_val(tag, {31'd0, pkt_start}, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 3000) begin
      tick();
      n++;
    end
    check_val(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic cfg_write(input logic [6:0] a, input logic [31:0] d);
    serial_addr   = a;
    serial_data   = d;
    serial_strobe = 1'b1;
    tick();
    serial_strobe = 1'b0;
  endtask

  // Scoreboard: every pkt_start must match the next expected source.
  always @(negedge rxclk) begin
    if (pkt_start === 1'b1) begin
      starts_seen++;
      if (exp_q.size() == 0) begin
        check_val("unexpected_grant", {28'd0, rd_select}, 32'hFFFF_FFFF);
      end else begin
        check_val("grant_src", {28'd0, rd_select}, exp_q.pop_front());
      end
    end
  end

  // Builder model: pulse pkt_done a few cycles after each pkt_start.
  always @(negedge rxclk) begin
    if (pkt_done) pkt_done = 1'b0;
    if (pkt_start === 1'b1 && auto_done) begin
      dcnt = 2;
    end else if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0) pkt_done = 1'b1;
    end
  end

  initial begin
    int s0;
    usedw[0] = 10'd0;
    usedw[1] = 10'd0;
    usedw[2] = 10'd0;

    // Reset values
    repeat (3) tick();
    check_val("rst_rd_select", {28'd0, rd_select}, 32'd0);
    check_val("rst_pkt_start", {31'd0, pkt_start}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_timeout", {31'd0, timeout_err}, 32'd0);
    check_val("rst_grant_count", {16'd0, grant_count}, 32'd0);
    reset = 1'b1;
    tick();

    // Round-robin between two full data channels
    usedw[0] = 10'd300;
    usedw[1] = 10'd300;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(1);
    have_space = 1'b1;
    tick();
    check_val("lat_arb_no_start", {31'd0, pkt_start}, 32'd0);
    tick();
    check_val("lat_start", {31'd0, pkt_start}, 32'd1);
    for (int i = 0; i < 3; i++) wait_start("rr_start");
    have_space = 1'b0;
    wait_idle("rr_idle");

    // Command priority, then round-robin after priority is turned off
    usedw[1] = 10'd0;
    cmd_empty = 1'b0;
    exp_q.push_back(2);
    have_space = 1'b1;
    wait_start("prio_cmd_start");
    cmd_empty = 1'b1;
    exp_q.push_back(0);
    wait_start("prio_ch0_start");
    have_space = 1'b0;
    wait_idle("prio_idle");
    cfg_write(7'd81, 32'd0);
    cfg_write(7'd80, 32'h007);
    usedw[1] = 10'd300;
    cmd_empty = 1'b0;
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(0);
    have_space = 1'b1;
    for (int i = 0; i < 3; i++) wait_start("noprio_start");
    have_space = 1'b0;
    wait_idle("noprio_idle");

    // Threshold boundary and have_space gating
    cmd_empty = 1'b1;
    usedw[1] = 10'd0;
    usedw[0] = 10'd251;
    have_space = 1'b1;
    s0 = starts_seen;
    repeat (6) tick();
    check_val("below_thresh_none", starts_seen, s0);
    check_val("below_thresh_busy", {31'd0, busy}, 32'd0);
    usedw[0] = 10'd252;
    exp_q.push_back(0);
    tick();
    check_val("thresh_arb_no_start", {31'd0, pkt_start}, 32'd0);
    tick();
    check_val("thresh_start", {31'd0, pkt_start}, 32'd1);
    usedw[0] = 10'd400;
    have_space = 1'b0;
    wait_idle("thresh_idle");
    s0 = starts_seen;
    repeat (6) tick();
    check_val("no_space_none", starts_seen, s0);

    // Enable mask: only channel 1
    cfg_write(7'd80, 32'h002);
    usedw[0] = 10'd300;
    usedw[1] = 10'd300;
    cmd_empty = 1'b0;
    exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(1);
    have_space = 1'b1;
    for (int i = 0; i < 3; i++) wait_start("mask_start");
    have_space = 1'b0;
    wait_idle("mask_idle");

    // Watchdog timeout and clear
    auto_done = 1'b0;
    exp_q.push_back(1);
    have_space = 1'b1;
    wait_start("to_start");
    have_space = 1'b0;
    repeat (1024) tick();
    check_val("to_not_yet", {31'd0, timeout_err}, 32'd0);
    check_val("to_still_busy", {31'd0, busy}, 32'd1);
    tick();
    check_val("to_set", {31'd0, timeout_err}, 32'd1);
    check_val("to_idle", {31'd0, busy}, 32'd0);
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    check_val("to_cleared", {31'd0, timeout_err}, 32'd0);

    // Reset in the middle of WAIT
    exp_q.push_back(1);
    have_space = 1'b1;
    wait_start("mid_start");
    have_space = 1'b0;
    repeat (3) tick();
    check_val("mid_rd_select", {28'd0, rd_select}, 32'd1);
    check_val("mid_grant_count", {16'd0, grant_count}, starts_seen);
    reset = 1'b0;
    tick();
    check_val("mid_rst_rd_select", {28'd0, rd_select}, 32'd0);
    check_val("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_val("mid_rst_pkt_start", {31'd0, pkt_start}, 32'd0);
    check_val("mid_rst_grant_count", {16'd0, grant_count}, 32'd0);
    reset = 1'b1;
    auto_done = 1'b1;
    cmd_empty = 1'b1;
    exp_q.push_back(0);
    have_space = 1'b1;
    wait_start("post_rst_start");
    have_space = 1'b0;
    wait_idle("post_rst_idle");
    repeat (2) tick();

    check_val("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
